// File: rtl/hash_display_ctrl.sv
// Run/pause sequencer: one hash round per tick, serial shift-add-3 BCD conversion onto five digit outputs.
// Optional macro HASH_TIMEOUT_EN adds a bounded hash_done wait with a sticky hash_err flag.
module hash_display_ctrl #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter bit AUTO_RUN       = 1'b0
) (
  input  logic        sysclk,
  input  logic        rst_n,
  input  logic        button_pulse,
  input  logic        tick_5s,
  input  logic [15:0] student_id,
  output logic        hash_start,
  output logic [15:0] hash_seed,
  input  logic        hash_done,
  input  logic [15:0] hash_value,
  output logic        enable,
  output logic        busy,
  output logic [15:0] cur_hash,
  output logic [3:0]  D5_out,
  output logic [3:0]  D4_out,
  output logic [3:0]  D3_out,
  output logic [3:0]  D2_out,
  output logic [3:0]  D1_out,
  output logic        bcd_valid,
  output logic        hash_err
);

  typedef enum logic [2:0] {IDLE, HASH_REQ, HASH_WAIT, CONVERT, UPDATE} state_t;

  state_t      state, state_nx;
  logic        pending, first;
  logic [15:0] chain_id;
  logic [19:0] bcd;
  logic [15:0] bin;
  logic [3:0]  bit_cnt;
  logic        enable_nx, go, timeout;

  function automatic logic [19:0] add3(input logic [19:0] v);
    logic [19:0] r;
    logic [3:0]  nib;
    r = v;
    for (int i = 0; i < 5; i++) begin
      nib = v[4*i +: 4];
      if (nib >= 4'd5) r[4*i +: 4] = nib + 4'd3;
    end
    return r;
  endfunction

`ifdef HASH_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_cnt;
`endif

  assign busy       = (state != IDLE);
  assign hash_start = (state == HASH_REQ);

  always_comb begin
    enable_nx = enable ^ button_pulse;
    // toggle is resolved first so a same-cycle tick sees the new run mode
    go        = (state == IDLE) && enable_nx &&
                (tick_5s || pending || (button_pulse && !enable));
    timeout   = 1'b0;
`ifdef HASH_TIMEOUT_EN
    timeout   = (state == HASH_WAIT) && !hash_done && (wait_cnt == TO_LIMIT);
`endif
    state_nx  = state;
    case (state)
      IDLE:      if (go) state_nx = HASH_REQ;
      HASH_REQ:  state_nx = HASH_WAIT;
      HASH_WAIT: begin
        if (hash_done)    state_nx = CONVERT;
        else if (timeout) state_nx = IDLE;
      end
      CONVERT:   if (bit_cnt == 4'd15) state_nx = UPDATE;
      UPDATE:    state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      enable    <= AUTO_RUN;
      pending   <= 1'b0;
      first     <= 1'b1;
      chain_id  <= '0;
      hash_seed <= '0;
      cur_hash  <= '0;
      bcd_valid <= 1'b0;
      D5_out    <= '0;
      D4_out    <= '0;
      D3_out    <= '0;
      D2_out    <= '0;
      D1_out    <= '0;
    end else begin
      state     <= state_nx;
      enable    <= enable_nx;
      bcd_valid <= (state == UPDATE);

      if (!enable_nx)             pending <= 1'b0;
      else if (go)                pending <= 1'b0;
      else if (tick_5s && busy)   pending <= 1'b1;

      // a new or changed student_id restarts the chain from the id itself
      if (go) begin
        if (first || (student_id != chain_id)) begin
          hash_seed <= student_id;
          chain_id  <= student_id;
          first     <= 1'b0;
        end else begin
          hash_seed <= cur_hash;
        end
      end

      if ((state == HASH_WAIT) && hash_done) cur_hash <= hash_value;

      if (state == UPDATE) begin
        D5_out <= bcd[19:16];
        D4_out <= bcd[15:12];
        D3_out <= bcd[11:8];
        D2_out <= bcd[7:4];
        D1_out <= bcd[3:0];
      end
    end
  end

  // conversion datapath is reloaded on every round, so it carries no reset
  always_ff @(posedge sysclk) begin
    if ((state == HASH_WAIT) && hash_done) begin
      bin     <= hash_value;
      bcd     <= '0;
      bit_cnt <= '0;
    end else if (state == CONVERT) begin
      {bcd, bin} <= {add3(bcd), bin} << 1;
      bit_cnt    <= bit_cnt + 4'd1;
    end
  end

`ifdef HASH_TIMEOUT_EN
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      hash_err <= 1'b0;
    end else begin
      if (state == HASH_REQ)       wait_cnt <= '0;
      else if (state == HASH_WAIT) wait_cnt <= wait_cnt + 16'd1;
      if (timeout)                 hash_err <= 1'b1;
      else if (state == UPDATE)    hash_err <= 1'b0;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign hash_err       = 1'b0;
`endif

endmodule

// File: tb/tb_hash_display_ctrl.sv
// Bench for hash_display_ctrl: behavioural round model checked every cycle, directed and random rounds.
module tb_hash_display_ctrl;
  localparam int TO = 16;

  logic        sysclk = 1'b0;
  logic        rst_n, button_pulse, tick_5s, hash_done;
  logic [15:0] student_id, hash_value;
  logic        hash_start, enable, busy, bcd_valid, hash_err;
  logic [15:0] hash_seed, cur_hash;
  logic [3:0]  D5_out, D4_out, D3_out, D2_out, D1_out;

  hash_display_ctrl #(.TIMEOUT_CYCLES(TO), .AUTO_RUN(1'b0)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .button_pulse(button_pulse), .tick_5s(tick_5s),
    .student_id(student_id), .hash_start(hash_start), .hash_seed(hash_seed),
    .hash_done(hash_done), .hash_value(hash_value), .enable(enable), .busy(busy),
    .cur_hash(cur_hash), .D5_out(D5_out), .D4_out(D4_out), .D3_out(D3_out),
    .D2_out(D2_out), .D1_out(D1_out), .bcd_valid(bcd_valid), .hash_err(hash_err)
  );

  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  int starts = 0, last_lat = 0;
  logic [15:0] last_seed = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [19:0] dec5(input int v);
    return {4'(v / 10000 % 10), 4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // bench hasher
  bit          mute = 1'b0, use_fixed = 1'b1;
  int          fixed_lat = 3;
  logic [15:0] fixed_val = '0;
  initial begin
    int          lat;
    logic [15:0] val;
    hash_done  = 1'b0;
    hash_value = '0;
    forever begin
      @(negedge sysclk);
      if (hash_start && !mute && rst_n) begin
        lat = use_fixed ? fixed_lat : int'($urandom_range(1, 8));
        val = use_fixed ? fixed_val : 16'($urandom);
        repeat (lat) @(posedge sysclk);
        #1; hash_done = 1'b1; hash_value = val;
        @(posedge sysclk);
        #1; hash_done = 1'b0; hash_value = 16'($urandom);
        if (!use_fixed && ($urandom_range(0, 1) == 1)) begin
          // stray completion while converting must be ignored
          repeat (3) @(posedge sysclk);
          #1; hash_done = 1'b1; hash_value = 16'($urandom);
          @(posedge sysclk);
          #1; hash_done = 1'b0;
        end
      end
    end
  end

  // behavioural model of rounds, checked on every falling edge
  bit          m_en, m_inflight, m_pending, m_first, m_err;
  logic [15:0] m_chain, m_cur, m_val, m_shown, m_seed;
  int          m_start_cyc, m_done_cyc, m_req_due;

  always @(negedge sysclk) begin : model
    logic        exp_valid, en_new, idle_now;
    logic [15:0] exp_seed;
    if (!rst_n) begin
      m_en = 1'b0; m_inflight = 1'b0; m_pending = 1'b0; m_first = 1'b1; m_err = 1'b0;
      m_chain = '0; m_cur = '0; m_val = '0; m_shown = '0; m_seed = '0;
      m_start_cyc = -100; m_done_cyc = -1; m_req_due = -1;
    end else begin
      chk("enable", enable, m_en);
      chk("hash_start", hash_start, cyc == m_req_due);
      chk("cur_hash", cur_hash, m_cur);
      if (hash_start) begin
        starts++;
        last_seed = hash_seed;
        exp_seed  = (m_first || student_id != m_chain) ? student_id : m_cur;
        if (m_first || student_id != m_chain) begin
          m_chain = student_id;
          m_first = 1'b0;
        end
        chk("hash_seed", hash_seed, exp_seed);
        m_seed = exp_seed;
        m_inflight = 1'b1; m_start_cyc = cyc; m_done_cyc = -1;
      end else if (m_inflight && m_done_cyc < 0) begin
        chk("seed_hold", hash_seed, m_seed);
      end
      if (m_inflight && m_done_cyc < 0 && hash_done && cyc > m_start_cyc) begin
        m_done_cyc = cyc; m_val = hash_value; m_cur = hash_value;
      end
      // done sampled at the end of cycle N -> digits visible from cycle N+18
      exp_valid = m_inflight && (m_done_cyc >= 0) && (cyc == m_done_cyc + 18);
      chk("bcd_valid", bcd_valid, exp_valid);
      if (exp_valid) begin
        m_shown = m_val; m_inflight = 1'b0; m_err = 1'b0; last_lat = cyc - m_done_cyc;
      end
`ifdef HASH_TIMEOUT_EN
      if (m_inflight && m_done_cyc < 0 && cyc == m_start_cyc + TO + 1) begin
        m_inflight = 1'b0; m_err = 1'b1;
      end
`endif
      chk("digits", {D5_out, D4_out, D3_out, D2_out, D1_out}, dec5(int'(m_shown)));
      chk("busy", busy, m_inflight);
      chk("hash_err", hash_err, m_err);
      en_new   = m_en ^ button_pulse;
      idle_now = !m_inflight;
      if (idle_now && en_new && (tick_5s || m_pending || (button_pulse && !m_en))) begin
        m_req_due = cyc + 1; m_pending = 1'b0;
      end else if (!en_new) m_pending = 1'b0;
      else if (tick_5s && !idle_now) m_pending = 1'b1;
      m_en = en_new;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge sysclk);
    #2;
  endtask
  task automatic tick();
    tick_5s = 1'b1; step(1); tick_5s = 1'b0;
  endtask
  task automatic press();
    button_pulse = 1'b1; step(1); button_pulse = 1'b0;
  endtask
  task automatic wait_valid();
    int n = 0;
    while (!bcd_valid && n < 80) begin step(1); n++; end
    chk("wait_bcd_valid", n < 80, 1);
    step(1);
  endtask
  task automatic wait_idle();
    int n = 0, c = 0;
    while (c < 3 && n < 200) begin
      if (!busy) c++; else c = 0;
      step(1); n++;
    end
    chk("wait_idle", n < 200, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int s0, vcount, n;
    rst_n = 1'b0; button_pulse = 1'b0; tick_5s = 1'b0; student_id = '0;
    step(3);
    chk("rst_enable", enable, 0);     chk("rst_busy", busy, 0);
    chk("rst_start", hash_start, 0);  chk("rst_seed", hash_seed, 0);
    chk("rst_cur", cur_hash, 0);      chk("rst_valid", bcd_valid, 0);
    chk("rst_err", hash_err, 0);
    chk("rst_digits", {D5_out, D4_out, D3_out, D2_out, D1_out}, 0);
    rst_n = 1'b1; step(2);

    student_id = 16'd12345; fixed_val = 16'd65535; step(2);
    press(); wait_valid();
    chk("r1_seed", last_seed, 12345);
    chk("r1_digits", {D5_out, D4_out, D3_out, D2_out, D1_out}, 20'h65535);
    chk("r1_cur", cur_hash, 65535);
    chk("r1_latency", last_lat, 18);

    fixed_val = 16'd0; step(3); tick(); wait_valid();
    chk("r2_chain_seed", last_seed, 65535);
    chk("r2_digits", {D5_out, D4_out, D3_out, D2_out, D1_out}, 20'h00000);
    chk("r2_single_pulse", bcd_valid, 0);

    s0 = starts; fixed_val = 16'd777; step(3);
    tick(); step(3); tick(); step(2); tick(); step(2); tick();
    wait_valid(); wait_valid(); step(40);
    chk("pending_rounds", starts - s0, 2);
    chk("r3_digits", {D5_out, D4_out, D3_out, D2_out, D1_out}, 20'h00777);

    wait_idle(); student_id = 16'd40000; step(2); fixed_val = 16'd9; tick(); wait_valid();
    chk("r4_seed", last_seed, 40000);
    chk("r4_digits", {D5_out, D4_out, D3_out, D2_out, D1_out}, 20'h00009);

    wait_idle(); s0 = starts; press(); tick(); step(20);
    chk("paused_no_round", starts - s0, 0);
    chk("paused_enable", enable, 0);
    press(); wait_valid();
    chk("resume_round", starts - s0, 1);

    use_fixed = 1'b0;
    for (int it = 0; it < 25; it++) begin
      wait_idle();
      if ($urandom_range(0, 2) == 0) student_id = 16'($urandom);
      step(2);
      case ($urandom_range(0, 3))
        0: tick();
        1: begin tick(); step($urandom_range(2, 10)); tick(); end
        2: begin tick(); step($urandom_range(3, 12)); press(); step($urandom_range(5, 30)); press(); end
        default: begin press(); tick(); step(5); press(); end
      endcase
    end
    wait_idle(); step(30);

    use_fixed = 1'b1; fixed_lat = 3; fixed_val = 16'd4321;
    tick(); n = 0;
    while (!hash_done && n < 50) begin step(1); n++; end
    chk("rst_test_done_seen", n < 50, 1);
    step(8);
    rst_n = 1'b0; #1;
    chk("arst_enable", enable, 0);   chk("arst_busy", busy, 0);
    chk("arst_cur", cur_hash, 0);    chk("arst_seed", hash_seed, 0);
    chk("arst_valid", bcd_valid, 0); chk("arst_start", hash_start, 0);
    chk("arst_digits", {D5_out, D4_out, D3_out, D2_out, D1_out}, 0);
    step(3); rst_n = 1'b1; vcount = 0;
    repeat (30) begin step(1); if (bcd_valid) vcount++; end
    chk("arst_no_valid", vcount, 0);
    chk("arst_enable_after", enable, 0);

`ifdef HASH_TIMEOUT_EN
    mute = 1'b1; press(); step(30);
    chk("to_err", hash_err, 1);
    chk("to_idle", busy, 0);
    chk("to_digits", {D5_out, D4_out, D3_out, D2_out, D1_out}, 0);
    mute = 1'b0; fixed_val = 16'd100; tick(); wait_valid();
    chk("to_err_cleared", hash_err, 0);
    chk("to_digits_after", {D5_out, D4_out, D3_out, D2_out, D1_out}, 20'h00100);
`endif

    step(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hash_display_ctrl.md
Name: hash_display_ctrl

Overview:
- Sequencer between the debounced button, the 5 s tick divider, the hasher and the 5-digit BCD display.
- Runs/pauses on button presses and issues one hash round per tick through a start/done handshake.
- Converts each 16-bit hash to five BCD digits serially (shift-add-3) and drives D5_out..D1_out.

Parameters:
- TIMEOUT_CYCLES, 1024: hash_done wait limit in cycles; used only when HASH_TIMEOUT_EN is defined.
- AUTO_RUN, 0: reset value of enable; 1 starts in run mode.

Ports:
- sysclk  in  1  system clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- button_pulse  in  1  one-cycle debounced press; toggles run/pause
- tick_5s  in  1  one-cycle round trigger
- student_id  in  16  chain seed
- hash_start  out  1  one-cycle request to hasher
- hash_seed  out  16  hasher input; stable from hash_start until hash_done
- hash_done  in  1  one-cycle hasher completion
- hash_value  in  16  hasher result; valid with hash_done
- enable  out  1  run mode
- busy  out  1  high in every state except IDLE
- cur_hash  out  16  last completed hash
- D5_out..D1_out  out  4 each  BCD digits, D5 = ten-thousands
- bcd_valid  out  1  one-cycle pulse when digits update
- hash_err  out  1  sticky timeout flag

Behaviour:
- Reset (async, any state): state=IDLE; enable=AUTO_RUN; cur_hash, hash_seed and all digits 0; hash_start, bcd_valid, hash_err, pending 0; chain_id=0; first=1.
- States:
  - IDLE -> HASH_REQ when enable & (tick_5s | pending | enable rose this cycle).
  - HASH_REQ: hash_start=1 for exactly 1 cycle -> HASH_WAIT.
  - HASH_WAIT: on hash_done, cur_hash<=hash_value and load shifter -> CONVERT.
  - CONVERT: exactly 16 cycles of shift-add-3 on a 20-bit BCD + 16-bit binary register -> UPDATE.
  - UPDATE: 1 cycle -> IDLE.
- Seed selection in HASH_REQ:
  - If first=1 or student_id != chain_id: hash_seed=student_id, chain_id<=student_id, first<=0.
  - Otherwise: hash_seed=cur_hash.
- button_pulse toggles enable in any state.
  - Pausing mid-round: the round completes and pending is cleared.
  - Pausing from IDLE: no new round starts.
- tick_5s with busy=1 and enable=1 sets pending (one deep; further ticks are lost). pending clears on entry to HASH_REQ. tick_5s with enable=0 is ignored.
- button_pulse and tick_5s in the same cycle: the toggle is applied first; the tick is evaluated against the new enable.
- Latency:
  - hash_done sampled high in cycle N: D*_out update and bcd_valid=1 on the edge ending cycle N+17.
  - bcd_valid is high for exactly 1 cycle.
- D*_out hold their value between updates. 65535 is the maximum value, so D5 <= 6 and no digit exceeds 9.
- hash_start outside HASH_REQ: never. hash_done outside HASH_WAIT: ignored.
- hash_err clears on any successful UPDATE.

Optional Feature:
- HASH_TIMEOUT_EN defined:
  - 16-bit wait counter in HASH_WAIT.
  - After TIMEOUT_CYCLES cycles with no hash_done: hash_err<=1, go to IDLE; cur_hash and digits unchanged; pending kept.
- Not defined:
  - HASH_WAIT waits indefinitely.
  - hash_err is constant 0.

Test Plan:
- Reset; student_id=12345; button_pulse; bench hasher returns 65535 three cycles after hash_start -> hash_seed=12345; digits 6,5,5,3,5; bcd_valid exactly 17 cycles after hash_done; cur_hash=65535.
- Second tick_5s, hasher returns 0 -> hash_seed=65535 (chain); digits 0,0,0,0,0; bcd_valid single pulse.
- Three tick_5s pulses while busy -> exactly one extra round after UPDATE; hash_start count = 2 in total.
- Change student_id to 40000 between rounds, then tick -> hash_seed=40000. Hasher returns 9 -> digits 0,0,0,0,9.
- Assert rst_n low during CONVERT cycle 8 -> all outputs 0 immediately; no bcd_valid after release; enable=AUTO_RUN.
- HASH_TIMEOUT_EN with TIMEOUT_CYCLES=16; hasher never responds -> hash_err=1 after 16 cycles in HASH_WAIT; state IDLE; digits unchanged. Next successful round clears hash_err.
